// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate / load-data extender.
// Result sits behind a 2-entry valid/ready skid buffer.
module ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_mode,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    typedef enum logic [2:0] {
        M_ZERO = 3'd0,
        M_SIGN = 3'd1,
        M_LUI  = 3'd2,
        M_LBU  = 3'd3,
        M_LB   = 3'd4,
        M_LHU  = 3'd5,
        M_LH   = 3'd6,
        M_PASS = 3'd7
    } mode_e;

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] ext_res;
    logic              ext_err;

    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic              o_err_q, o_err_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              s_err_q, s_err_d;
    logic              sv_q, sv_d;

    logic in_xfer;
    logic out_xfer;

    // Bring the addressed byte / halfword down to bit 0.
    assign byte_sh = in_data >> {in_off, 3'b000};
    assign half_sh = in_data >> {in_off[OFF_W-1:1], 4'b0000};
    assign imm     = in_data[IMM_W-1:0];

    // Extension of the incoming operand; misaligned halves yield 0 + err.
    always_comb begin
        ext_res = '0;
        ext_err = 1'b0;
        case (mode_e'(in_mode))
            M_ZERO: ext_res = {{(DATA_W-IMM_W){1'b0}}, imm};
            M_SIGN: ext_res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            M_LUI:  ext_res = {imm, {(DATA_W-IMM_W){1'b0}}};
            M_LBU:  ext_res = {{(DATA_W-8){1'b0}}, byte_sh[7:0]};
            M_LB:   ext_res = {{(DATA_W-8){byte_sh[7]}}, byte_sh[7:0]};
            M_LHU: begin
                if (in_off[0]) ext_err = 1'b1;
                else ext_res = {{(DATA_W-16){1'b0}}, half_sh[15:0]};
            end
            M_LH: begin
                if (in_off[0]) ext_err = 1'b1;
                else ext_res = {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]};
            end
            M_PASS: ext_res = in_data;
            default: ext_res = '0;
        endcase
    end

    assign in_xfer  = in_valid && !sv_q;
    assign out_xfer = ov_q && out_ready;

    // Skid-buffer next state; flush overrides every transfer.
    always_comb begin
        o_data_d = o_data_q;
        o_err_d  = o_err_q;
        ov_d     = ov_q;
        s_data_d = s_data_q;
        s_err_d  = s_err_q;
        sv_d     = sv_q;
        if (flush) begin
            ov_d = 1'b0;
            sv_d = 1'b0;
        end else if (sv_q) begin
            if (out_xfer) begin
                o_data_d = s_data_q;
                o_err_d  = s_err_q;
                sv_d     = 1'b0;
            end
        end else if (in_xfer) begin
            if (!ov_q || out_ready) begin
                o_data_d = ext_res;
                o_err_d  = ext_err;
                ov_d     = 1'b1;
            end else begin
                s_data_d = ext_res;
                s_err_d  = ext_err;
                sv_d     = 1'b1;
            end
        end else if (out_xfer) begin
            ov_d = 1'b0;
        end
    end

    // Buffer state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data_q <= '0;
            o_err_q  <= 1'b0;
            ov_q     <= 1'b0;
            s_data_q <= '0;
            s_err_q  <= 1'b0;
            sv_q     <= 1'b0;
        end else begin
            o_data_q <= o_data_d;
            o_err_q  <= o_err_d;
            ov_q     <= ov_d;
            s_data_q <= s_data_d;
            s_err_q  <= s_err_d;
            sv_q     <= sv_d;
        end
    end

    assign in_ready  = !sv_q;
    assign out_valid = ov_q;
    assign out_data  = o_data_q;
    assign out_err   = o_err_q;

endmodule
